spi_regbank: RTL and testbench
==============================

Name: spi_regbank

Overview:
- Parametrised register bank between the SPI slave driver (frame-level cmd/data pulses) and user logic.
- Generalises the fixed 4x16-bit register interface:
  - configurable width and register counts;
  - separate read-only and read-write regions;
  - auto-increment bursts across multiple data frames in one chip-select window;
  - out-of-range error flag;
  - per-register write strobes.

Parameters:
- DATA_W, 16, register and SPI data-frame width.
- CMD_W, 8, command width; MSB = 1 read / 0 write, low CMD_W-1 bits = address.
- N_RO, 1, number of read-only registers, addresses 0..N_RO-1.
- N_RW, 3, number of read-write registers, addresses N_RO..N_RO+N_RW-1. N_RO+N_RW <= 2^(CMD_W-1).
- AUTO_INC, 1, 1 = pointer increments after every data frame; 0 = pointer fixed for the whole transfer.
- RW_RESET, 0, reset value of every RW register (DATA_W bits).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- cmd_valid, input, 1, one-cycle pulse: command frame received (driver done_cmd).
- cmd, input, CMD_W, command byte; valid when cmd_valid = 1.
- data_valid, input, 1, one-cycle pulse: data frame completed (driver done_data).
- data_in, input, DATA_W, received data frame; valid when data_valid = 1.
- xfer_end, input, 1, one-cycle pulse: data chip-select deasserted.
- rd_data, output, DATA_W, word the driver shifts out in the next data frame.
- ro_in, input, N_RO*DATA_W, read-only register sources; reg k = bits [k*DATA_W +: DATA_W].
- rw_out, output, N_RW*DATA_W, RW register contents, same packing.
- wr_strobe, output, N_RW, one-cycle pulse per RW register when it is updated.
- addr_err, output, 1, sticky out-of-range access flag.
- busy, output, 1, high while state != IDLE.

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst. All state changes on the rising edge of clk.
- Reset values:
  - state = IDLE; ptr = 0.
  - rd_data = 0; wr_strobe = 0; addr_err = 0; busy = 0.
  - Every RW register = RW_RESET.
  - RO snapshot = 0.
- RO sampling: ro_in is registered every cycle into the snapshot; reads return the snapshot, i.e. 1 cycle stale.
- State machine states: IDLE, WRITE, READ.
  - cmd_valid in any state → ptr <= cmd[CMD_W-2:0]; next state = READ if cmd MSB = 1, else WRITE; addr_err <= 0.
  - Address validity check: the cmd address itself is not checked at cmd_valid; validity is checked at each access.
  - WRITE, on data_valid:
    - If ptr is an RW address: reg[ptr-N_RO] <= data_in, and the matching wr_strobe bit pulses in the same cycle the register updates.
    - If ptr is an RO address: ignored silently.
    - If ptr >= N_RO+N_RW: ignored, addr_err <= 1.
    - Then ptr advances by AUTO_INC.
  - READ:
    - rd_data <= value at ptr, 1 cycle after cmd_valid and 1 cycle after each data_valid, the latter using the already-incremented ptr.
    - Out-of-range ptr → rd_data <= 0 and addr_err <= 1.
    - data_valid → ptr advances by AUTO_INC.
  - xfer_end → IDLE. rd_data holds its value; ptr holds its value.
- Wrap-around: ptr increments modulo N_RO+N_RW. After the last RW register, ptr returns to 0.
- Event priorities:
  - cmd_valid together with data_valid: cmd_valid wins; the data frame is dropped.
  - data_valid together with xfer_end: the frame is processed, then the state becomes IDLE.
  - data_valid in IDLE: ignored.
- rst asserted mid-transfer: immediate return to reset values, including RW registers; no partial strobes.
- Arithmetic: address compares use CMD_W-1 bits, zero-extended; ptr width = CMD_W-1.

Optional Feature:
- Macro: SPI_REGBANK_SHADOW_EN.
- Defined:
  - WRITE frames update a shadow copy plus a per-register dirty bit.
  - On xfer_end in WRITE state, all dirty shadows are copied to rw_out in one cycle; wr_strobe pulses for every dirty register simultaneously, then dirty bits clear.
  - cmd_valid before xfer_end discards pending dirty data.
  - Reads of RW addresses return the committed rw_out value, not the shadow.
- Undefined: each write lands in rw_out immediately as described above; no shadow storage is built.

Test Plan:
1. Defaults: after rst, write cmd 0x02 + data 0xBEEF → rw_out reg1 = 0xBEEF, wr_strobe = 3'b010 for 1 cycle; read cmd 0x82 → rd_data = 0xBEEF one cycle after cmd_valid.
2. Burst write: cmd 0x01, frames 0x1111, 0x2222, 0x3333 → RW regs = 0x1111 / 0x2222 / 0x3333. A 4th frame wraps to address 0 (RO): no change, addr_err stays 0.
3. Read burst: ro_in = 0x00A5, cmd 0x80, three data_valid pulses → rd_data sequence 0x00A5, reg1, reg2, reg3.
4. Out of range: write cmd 0x10 with data 0xFFFF → no wr_strobe, addr_err = 1. Next cmd_valid clears addr_err; read 0x90 → rd_data = 0, addr_err = 1.
5. Collisions: cmd_valid and data_valid in the same cycle → data dropped. rst during a burst after 1 frame → all RW = RW_RESET, busy = 0.
6. With SPI_REGBANK_SHADOW_EN: burst write 0x01..0x03 → rw_out unchanged until xfer_end, then all three update in the same cycle with wr_strobe = 3'b111.

Source files
------------

// File: rtl/spi_regbank_if.sv
// Frame-level handshake between the SPI slave driver and the register bank.
// Master = driver side, slave = register bank.
interface spi_regbank_if #(
    parameter int CMD_W  = 8,
    parameter int DATA_W = 16
);
    logic              cmd_valid;
    logic [CMD_W-1:0]  cmd;
    logic              data_valid;
    logic [DATA_W-1:0] data_in;
    logic              xfer_end;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output cmd_valid, cmd, data_valid, data_in, xfer_end,
        input  rd_data
    );

    modport slave (
        input  cmd_valid, cmd, data_valid, data_in, xfer_end,
        output rd_data
    );
endinterface

// File: rtl/spi_regbank.sv
// Parametrised SPI register bank: RO snapshot region, RW region, bursts.
// Define SPI_REGBANK_SHADOW_EN to stage writes and commit them on xfer_end.
module spi_regbank #(
    parameter int                CMD_W    = 8,
    parameter int                DATA_W   = 16,
    parameter int                N_RO     = 1,
    parameter int                N_RW     = 3,
    parameter int                AUTO_INC = 1,
    parameter logic [DATA_W-1:0] RW_RESET = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    spi_regbank_if.slave             bus,
    input  logic [N_RO*DATA_W-1:0]   ro_in_i,
    output logic [N_RW*DATA_W-1:0]   rw_out_o,
    output logic [N_RW-1:0]          wr_strobe_o,
    output logic                     addr_err_o,
    output logic                     busy_o
);
    localparam int AW = CMD_W - 1;
    localparam int N  = N_RO + N_RW;

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
    typedef logic [N_RO-1:0][DATA_W-1:0] ro_t;
    typedef logic [N_RW-1:0][DATA_W-1:0] rw_t;

    state_t            state_q;
    logic [AW-1:0]     ptr_q;
    logic [DATA_W-1:0] rd_q;
    logic [N_RW-1:0]   strb_q;
    logic              err_q;
    ro_t               ro_q;
    rw_t               rw_q;

    logic [AW-1:0]     cmd_addr;
    logic              cmd_rd;
    logic              cmd_oor;
    logic [DATA_W-1:0] cmd_val;
    logic [AW:0]       p1;
    logic [AW-1:0]     ptr_nx;
    logic              nx_oor;
    logic [DATA_W-1:0] nx_val;
    logic              ptr_oor;
    logic [N_RW-1:0]   wr_hit;

    // Returns {out_of_range, data}; RW reads always see committed values.
    function automatic logic [DATA_W:0] lookup(
        input logic [AW-1:0] a,
        input ro_t           ro,
        input rw_t           rw
    );
        logic [DATA_W:0] r;
        r = {1'b1, {DATA_W{1'b0}}};
        for (int k = 0; k < N_RO; k++)
            if (a == AW'(k)) r = {1'b0, ro[k]};
        for (int k = 0; k < N_RW; k++)
            if (a == AW'(N_RO + k)) r = {1'b0, rw[k]};
        return r;
    endfunction

    always_comb begin
        cmd_addr = bus.cmd[CMD_W-2:0];
        cmd_rd   = bus.cmd[CMD_W-1];
        {cmd_oor, cmd_val} = lookup(cmd_addr, ro_q, rw_q);
        p1 = {1'b0, ptr_q} + 1'b1;
        if (AUTO_INC == 0)
            ptr_nx = ptr_q;
        else if (p1 >= (AW+1)'(N))
            ptr_nx = '0;
        else
            ptr_nx = p1[AW-1:0];
        {nx_oor, nx_val} = lookup(ptr_nx, ro_q, rw_q);
        ptr_oor = {1'b0, ptr_q} >= (AW+1)'(N);
        for (int k = 0; k < N_RW; k++)
            wr_hit[k] = (state_q == WRITE) && bus.data_valid &&
                        !bus.cmd_valid && (ptr_q == AW'(N_RO + k));
    end

`ifdef SPI_REGBANK_SHADOW_EN
    rw_t             sh_q;
    rw_t             sh_n;
    logic [N_RW-1:0] dirty_q;
    logic [N_RW-1:0] dirty_n;

    always_comb begin
        sh_n    = sh_q;
        dirty_n = dirty_q | wr_hit;
        for (int k = 0; k < N_RW; k++)
            if (wr_hit[k]) sh_n[k] = bus.data_in;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rd_q    <= '0;
            strb_q  <= '0;
            err_q   <= 1'b0;
            ro_q    <= '0;
            for (int k = 0; k < N_RW; k++) rw_q[k] <= RW_RESET;
`ifdef SPI_REGBANK_SHADOW_EN
            sh_q    <= '0;
            dirty_q <= '0;
`endif
        end else begin
            ro_q   <= ro_in_i;
            strb_q <= '0;
            if (bus.cmd_valid) begin
                ptr_q   <= cmd_addr;
                state_q <= cmd_rd ? READ : WRITE;
                err_q   <= cmd_rd & cmd_oor;
                if (cmd_rd) rd_q <= cmd_val;
`ifdef SPI_REGBANK_SHADOW_EN
                dirty_q <= '0;
`endif
            end else begin
                if (state_q == WRITE && bus.data_valid) begin
                    ptr_q <= ptr_nx;
                    if (ptr_oor) err_q <= 1'b1;
`ifdef SPI_REGBANK_SHADOW_EN
                    sh_q    <= sh_n;
                    dirty_q <= dirty_n;
`else
                    for (int k = 0; k < N_RW; k++)
                        if (wr_hit[k]) rw_q[k] <= bus.data_in;
                    strb_q <= wr_hit;
`endif
                end
                if (state_q == READ && bus.data_valid) begin
                    ptr_q <= ptr_nx;
                    rd_q  <= nx_val;
                    if (nx_oor) err_q <= 1'b1;
                end
`ifdef SPI_REGBANK_SHADOW_EN
                // Commit includes a frame arriving in the same cycle.
                if (bus.xfer_end && state_q == WRITE) begin
                    for (int k = 0; k < N_RW; k++)
                        if (dirty_n[k]) rw_q[k] <= sh_n[k];
                    strb_q  <= dirty_n;
                    dirty_q <= '0;
                end
`endif
                if (bus.xfer_end) state_q <= IDLE;
            end
        end
    end

    assign bus.rd_data = rd_q;
    assign rw_out_o    = rw_q;
    assign wr_strobe_o = strb_q;
    assign addr_err_o  = err_q;
    assign busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_spi_regbank.sv
// Directed bench for spi_regbank with default parameters.
// Shadow-commit checks run when SPI_REGBANK_SHADOW_EN is defined.
module tb_spi_regbank;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ro_in;
    logic [47:0] rw_out;
    logic [2:0]  wr_strobe;
    logic        addr_err;
    logic        busy;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [2:0]  strb_acc;
    int          strb_cnt;

    spi_regbank_if #(.CMD_W(8), .DATA_W(16)) bus ();

    spi_regbank dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .ro_in_i     (ro_in),
        .rw_out_o    (rw_out),
        .wr_strobe_o (wr_strobe),
        .addr_err_o  (addr_err),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Every cycle advance goes through here so strobes are never missed.
    task automatic tick();
        @(posedge clk);
        #1;
        strb_acc |= wr_strobe;
        if (wr_strobe != 3'b000) strb_cnt++;
    endtask

    task automatic clr_strb();
        strb_acc = '0;
        strb_cnt = 0;
    endtask

    task automatic cmd_p(input logic [7:0] c);
        bus.cmd_valid = 1'b1;
        bus.cmd       = c;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic dat_p(input logic [15:0] d, input logic xe);
        bus.data_valid = 1'b1;
        bus.data_in    = d;
        bus.xfer_end   = xe;
        tick();
        bus.data_valid = 1'b0;
        bus.xfer_end   = 1'b0;
    endtask

    task automatic xend();
        bus.xfer_end = 1'b1;
        tick();
        bus.xfer_end = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        ro_in          = '0;
        bus.cmd_valid  = 1'b0;
        bus.cmd        = '0;
        bus.data_valid = 1'b0;
        bus.data_in    = '0;
        bus.xfer_end   = 1'b0;
        clr_strb();
        tick();
        tick();
        rst = 1'b0;
        chk("rst_rd",   64'(bus.rd_data), 64'h0);
        chk("rst_rw",   64'(rw_out),      64'h0);
        chk("rst_strb", 64'(wr_strobe),   64'h0);
        chk("rst_err",  64'(addr_err),    64'h0);
        chk("rst_busy", 64'(busy),        64'h0);

        // data in IDLE is ignored
        dat_p(16'h9999, 1'b0);
        tick();
        chk("idle_rw",   64'(rw_out),   64'h0);
        chk("idle_strb", 64'(strb_cnt), 64'h0);

        // single write then read back
        clr_strb();
        cmd_p(8'h02);
        chk("t1_busy", 64'(busy), 64'h1);
        dat_p(16'hBEEF, 1'b0);
        xend();
        tick();
        chk("t1_rw",     64'(rw_out),   64'h0000_BEEF_0000);
        chk("t1_strb",   64'(strb_acc), 64'h2);
        chk("t1_strbn",  64'(strb_cnt), 64'h1);
        chk("t1_idle",   64'(busy),     64'h0);
        cmd_p(8'h82);
        chk("t1_rd", 64'(bus.rd_data), 64'hBEEF);
        xend();

        // burst write with wrap into the RO register
        clr_strb();
        cmd_p(8'h01);
        dat_p(16'h1111, 1'b0);
        dat_p(16'h2222, 1'b0);
        dat_p(16'h3333, 1'b0);
        dat_p(16'h4444, 1'b0);
        xend();
        tick();
        chk("t2_rw",    64'(rw_out),   64'h3333_2222_1111);
        chk("t2_err",   64'(addr_err), 64'h0);
        chk("t2_strb",  64'(strb_acc), 64'h7);
        chk("t2_strbn", 64'(strb_cnt), 64'h3);

        // read burst starting at the RO register
        ro_in = 16'h00A5;
        tick();
        cmd_p(8'h80);
        chk("t3_rd0", 64'(bus.rd_data), 64'h00A5);
        dat_p(16'h0, 1'b0);
        chk("t3_rd1", 64'(bus.rd_data), 64'h1111);
        dat_p(16'h0, 1'b0);
        chk("t3_rd2", 64'(bus.rd_data), 64'h2222);
        dat_p(16'h0, 1'b0);
        chk("t3_rd3", 64'(bus.rd_data), 64'h3333);
        xend();
        chk("t3_hold", 64'(bus.rd_data), 64'h3333);

        // out of range write, then read
        clr_strb();
        cmd_p(8'h10);
        dat_p(16'hFFFF, 1'b0);
        xend();
        tick();
        chk("t4_strb", 64'(strb_cnt), 64'h0);
        chk("t4_err",  64'(addr_err), 64'h1);
        chk("t4_rw",   64'(rw_out),   64'h3333_2222_1111);
        cmd_p(8'h03);
        chk("t4_clr",  64'(addr_err), 64'h0);
        xend();
        cmd_p(8'h90);
        chk("t4_rd",   64'(bus.rd_data), 64'h0);
        chk("t4_rerr", 64'(addr_err),    64'h1);
        xend();

        // cmd_valid beats a same-cycle data frame
        clr_strb();
        cmd_p(8'h01);
        bus.cmd_valid  = 1'b1;
        bus.cmd        = 8'h02;
        bus.data_valid = 1'b1;
        bus.data_in    = 16'hDEAD;
        tick();
        bus.cmd_valid  = 1'b0;
        bus.data_valid = 1'b0;
        dat_p(16'h5555, 1'b0);
        xend();
        tick();
        chk("t5_col",   64'(rw_out),   64'h3333_5555_1111);
        chk("t5_strbn", 64'(strb_cnt), 64'h1);

        // frame together with xfer_end is still processed
        cmd_p(8'h03);
        dat_p(16'hABCD, 1'b1);
        tick();
        chk("t5_xe_rw",   64'(rw_out), 64'hABCD_5555_1111);
        chk("t5_xe_busy", 64'(busy),   64'h0);

        // reset in the middle of a burst
        cmd_p(8'h01);
        dat_p(16'h7777, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_rw",   64'(rw_out),      64'h0);
        chk("t5_rst_busy", 64'(busy),        64'h0);
        chk("t5_rst_strb", 64'(wr_strobe),   64'h0);
        chk("t5_rst_rd",   64'(bus.rd_data), 64'h0);

`ifdef SPI_REGBANK_SHADOW_EN
        clr_strb();
        cmd_p(8'h01);
        dat_p(16'h0101, 1'b0);
        dat_p(16'h0202, 1'b0);
        dat_p(16'h0303, 1'b0);
        chk("t6_hold", 64'(rw_out),   64'h0);
        chk("t6_nost", 64'(strb_cnt), 64'h0);
        xend();
        chk("t6_strb", 64'(wr_strobe), 64'h7);
        chk("t6_rw",   64'(rw_out),    64'h0303_0202_0101);
        tick();
        chk("t6_strb0", 64'(wr_strobe), 64'h0);
        cmd_p(8'h01);
        dat_p(16'hEEEE, 1'b0);
        cmd_p(8'h02);
        xend();
        chk("t6_disc", 64'(rw_out), 64'h0303_0202_0101);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
